// File: rtl/xgmii_tx_encoder.sv
// Clause 49 64b/66b transmit encoder: pairs two 4-lane XGMII half-words into one 66-bit block.
// Define TX_ENCODER_SCRAMBLE_EN to scramble o_txd with a self-synchronising x^58+x^39+1 scrambler.
module xgmii_tx_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] xgmii_txd,
  input  logic [3:0]            xgmii_txc,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_txd,
  output logic [1:0]            o_header,
  output logic                  o_header_valid
);

  // state   | meaning
  // PH_LOW  | capture lanes 0-3, emit low half of the previous block with its header
  // PH_HIGH | encode the completed block, emit high half of the previous block
  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("xgmii_tx_encoder supports DATA_WIDTH=32 only");
  end

  localparam logic [65:0] IDLE_BLK    = {56'h0, 8'h1E, 2'b01};
  localparam logic [63:0] ERR_PAYLOAD = {{8{7'h1E}}, 8'h1E};
  localparam logic [63:0] T_TYPES     = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};

  // Returns {payload, sync header}; unrecognised lane patterns become an error block.
  function automatic logic [65:0] encode(input logic [7:0] c, input logic [63:0] d);
    logic [63:0] p;
    logic        ok;
    logic [7:0]  lane;
    logic [7:0]  mask;
    if (c == 8'h00) return {d, 2'b10};
    p  = ERR_PAYLOAD;
    ok = (c == 8'hFF);
    for (int i = 0; i < 8; i++) begin
      lane = d[8*i +: 8];
      if (lane != 8'h07 && lane != 8'hFE) ok = 1'b0;
    end
    if (ok) begin
      p = {56'h0, 8'h1E};
      for (int i = 0; i < 8; i++)
        p[8+7*i +: 7] = (d[8*i +: 8] == 8'hFE) ? 7'h1E : 7'h00;
    end
    if (c == 8'h01 && d[7:0] == 8'hFB) p = {d[63:8], 8'h78};
    if (c == 8'h1F && d[39:0] == 40'hFB_0707_0707) p = {d[63:40], 4'h0, 28'h0, 8'h33};
    for (int k = 0; k < 8; k++) begin
      mask = 8'hFF << k;
      ok   = (c == mask) && (d[8*k +: 8] == 8'hFD);
      for (int j = 0; j < 8; j++)
        if (j > k && d[8*j +: 8] != 8'h07) ok = 1'b0;
      if (ok) begin
        p      = '0;
        p[7:0] = T_TYPES[8*k +: 8];
        for (int j = 0; j < 7; j++)
          if (j < k) p[8+8*j +: 8] = d[8*j +: 8];
      end
    end
    return {p, 2'b01};
  endfunction

  phase_t      phase_q, phase_d;
  logic [35:0] hold_q, hold_d;
  logic [65:0] blk_q, blk_d;
  logic [31:0] txd_d;
  logic [1:0]  hdr_d;
  logic        hv_d;
  logic [31:0] half_raw, half_out;

  assign half_raw = (phase_q == PH_LOW) ? blk_q[33:2] : blk_q[65:34];

`ifdef TX_ENCODER_SCRAMBLE_EN
  logic [57:0] scr_q, scr_d;

  // Bit 0 of the state is the most recently transmitted scrambled bit.
  always_comb begin
    scr_d    = scr_q;
    half_out = '0;
    for (int i = 0; i < 32; i++) begin
      half_out[i] = half_raw[i] ^ scr_d[38] ^ scr_d[57];
      scr_d       = {scr_d[56:0], half_out[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        scr_q <= '1;
    else if (i_ready) scr_q <= scr_d;
  end
`else
  assign half_out = half_raw;
`endif

  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    blk_d   = blk_q;
    txd_d   = o_txd;
    hdr_d   = o_header;
    hv_d    = o_header_valid;
    if (i_ready) begin
      txd_d = half_out;
      if (phase_q == PH_LOW) begin
        hold_d  = {xgmii_txc, xgmii_txd};
        hdr_d   = blk_q[1:0];
        hv_d    = 1'b1;
        phase_d = PH_HIGH;
      end else begin
        blk_d   = encode({xgmii_txc, hold_q[35:32]}, {xgmii_txd, hold_q[31:0]});
        hv_d    = 1'b0;
        phase_d = PH_LOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= PH_LOW;
      hold_q         <= '0;
      blk_q          <= IDLE_BLK;
      o_txd          <= '0;
      o_header       <= 2'b00;
      o_header_valid <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      hold_q         <= hold_d;
      blk_q          <= blk_d;
      o_txd          <= txd_d;
      o_header       <= hdr_d;
      o_header_valid <= hv_d;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Self-checking bench for xgmii_tx_encoder: directed clause 49 cases plus random blocks vs a field-packing model.
module tb_xgmii_tx_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] xgmii_txd;
  logic [3:0]  xgmii_txc;
  logic        i_ready;
  logic [31:0] o_txd;
  logic [1:0]  o_header;
  logic        o_header_valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] IDLE_D = 32'h0707_0707;
  localparam logic [3:0]  IDLE_C = 4'hF;

  // Expected per ready edge: {header (0 when not valid), header_valid, txd}
  logic [34:0] exp_q[$];
  logic [34:0] last_exp;
  bit          m_phase;
  logic [31:0] m_hold_d;
  logic [3:0]  m_hold_c;
  logic [7:0]  ttab [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  xgmii_tx_encoder #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
    .i_ready(i_ready), .o_txd(o_txd), .o_header(o_header), .o_header_valid(o_header_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Builds the block as a bit stream, appending clause 49 fields from bit 0 upward.
  function automatic logic [65:0] model_encode(input logic [7:0] c, input logic [63:0] d);
    logic [7:0]  b [8];
    logic [63:0] p;
    int          pos, t;
    bit          all_ie, term;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    if (c == 8'h00) return {d, 2'b10};
    p = '0; pos = 0; t = 0;
    while (t < 8 && c[t] == 1'b0) t++;
    all_ie = (c == 8'hFF);
    for (int i = 0; i < 8; i++) if (b[i] != 8'h07 && b[i] != 8'hFE) all_ie = 0;
    term = 0;
    if (t < 8) begin
      term = ((c >> t) == (8'hFF >> t)) && (b[t] == 8'hFD);
      for (int i = t + 1; i < 8; i++) if (b[i] != 8'h07) term = 0;
    end
    if (all_ie) begin
      p |= 64'h1E; pos = 8;
      for (int i = 0; i < 8; i++) begin
        p |= 64'((b[i] == 8'hFE) ? 7'h1E : 7'h00) << pos; pos += 7;
      end
    end else if (c == 8'h01 && b[0] == 8'hFB) begin
      p |= 64'h78; pos = 8;
      for (int i = 1; i < 8; i++) begin p |= 64'(b[i]) << pos; pos += 8; end
    end else if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07
                 && b[3] == 8'h07 && b[4] == 8'hFB) begin
      p |= 64'h33; pos = 8 + 4 * 7 + 4;
      for (int i = 5; i < 8; i++) begin p |= 64'(b[i]) << pos; pos += 8; end
    end else if (term) begin
      p |= 64'(ttab[t]); pos = 8;
      for (int i = 0; i < t; i++) begin p |= 64'(b[i]) << pos; pos += 8; end
      pos += 7 - t;
    end else begin
      p |= 64'h1E; pos = 8;
      for (int i = 0; i < 8; i++) begin p |= 64'(7'h1E) << pos; pos += 7; end
    end
    return {p, 2'b01};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({2'b01, 1'b1, 32'h0000_001E});
    exp_q.push_back({2'b00, 1'b0, 32'h0000_0000});
    last_exp = '0;
    m_phase  = 0;
  endtask

  task automatic step(input logic [31:0] d, input logic [3:0] c, input logic r,
                      output logic [34:0] obs, output logic [34:0] expv);
    logic [65:0] blk;
    xgmii_txd = d; xgmii_txc = c; i_ready = r;
    @(posedge clk);
    if (r) begin
      if (!m_phase) begin
        m_hold_d = d; m_hold_c = c;
      end else begin
        blk = model_encode({c, m_hold_c}, {d, m_hold_d});
        exp_q.push_back({blk[1:0], 1'b1, blk[33:2]});
        exp_q.push_back({2'b00, 1'b0, blk[65:34]});
      end
      m_phase  = !m_phase;
      last_exp = exp_q.pop_front();
    end
    #1;
    obs  = {(o_header_valid === 1'b1) ? o_header : 2'b00, o_header_valid, o_txd};
    expv = last_exp;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_ready = 1'b1;
    xgmii_txd = $urandom; xgmii_txc = 4'($urandom);
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (o_txd !== 32'h0 || o_header !== 2'b00 || o_header_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got txd=%h hdr=%b hv=%b want 0/00/0", o_txd, o_header, o_header_valid);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    logic [34:0] o, e, lit;
    for (int i = 0; i < 6; i++) begin
      step(IDLE_D, IDLE_C, 1'b1, o, e);
      lit = (i % 2 == 0) ? {2'b01, 1'b1, 32'h0000_001E} : 35'h0;
      total++;
      if (o !== lit) begin bad++; $display("FAIL idle[%0d]: got %h want %h", i, o, lit); end
    end
  endtask

  task automatic test_start();
    logic [34:0] o, e;
    step(32'h5555_55FB, 4'h1, 1'b1, o, e);
    step(32'hD555_5555, 4'h0, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b01, 1'b1, 32'h5555_5578}) begin bad++; $display("FAIL start_lo: got %h want %h", o, {2'b01, 1'b1, 32'h5555_5578}); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b00, 1'b0, 32'hD555_5555}) begin bad++; $display("FAIL start_hi: got %h want %h", o, {2'b00, 1'b0, 32'hD555_5555}); end
  endtask

  task automatic test_data();
    logic [34:0] o, e;
    step(32'h0403_0201, 4'h0, 1'b1, o, e);
    step(32'h0807_0605, 4'h0, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b10, 1'b1, 32'h0403_0201}) begin bad++; $display("FAIL data_lo: got %h want %h", o, {2'b10, 1'b1, 32'h0403_0201}); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b00, 1'b0, 32'h0807_0605}) begin bad++; $display("FAIL data_hi: got %h want %h", o, {2'b00, 1'b0, 32'h0807_0605}); end
  endtask

  task automatic test_terminate();
    logic [34:0] o, e;
    step(32'h0707_07FD, 4'hF, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b01, 1'b1, 32'h0000_0087}) begin bad++; $display("FAIL term0_lo: got %h want %h", o, {2'b01, 1'b1, 32'h0000_0087}); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== 35'h0) begin bad++; $display("FAIL term0_hi: got %h want 0", o); end
  endtask

  task automatic test_error();
    logic [34:0] o, e;
    logic [63:0] pay;
    step(32'h0403_9C01, 4'h2, 1'b1, o, e);
    step(32'h0807_0605, 4'h0, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    pay[31:0] = o[31:0];
    total++;
    if (o[34:32] !== 3'b011) begin bad++; $display("FAIL error_hdr: got %b want 011", o[34:32]); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    pay[63:32] = o[31:0];
    total++;
    if (pay[7:0] !== 8'h1E) begin bad++; $display("FAIL error_type: got %h want 1e", pay[7:0]); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (pay[8+7*i +: 7] !== 7'h1E) begin bad++; $display("FAIL error_code[%0d]: got %h want 1e", i, pay[8+7*i +: 7]); end
    end
  endtask

  task automatic test_ready_gap();
    logic [34:0] o, e, prev;
    step(32'h0403_0201, 4'h0, 1'b1, o, e);
    prev = o;
    step(32'h0807_0605, 4'h0, 1'b0, o, e);
    total++;
    if (o !== prev) begin bad++; $display("FAIL gap_freeze_in: got %h want %h", o, prev); end
    step(32'h0807_0605, 4'h0, 1'b1, o, e);
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b10, 1'b1, 32'h0403_0201}) begin bad++; $display("FAIL gap_lo: got %h want %h", o, {2'b10, 1'b1, 32'h0403_0201}); end
    step(IDLE_D, IDLE_C, 1'b0, o, e);
    total++;
    if (o !== {2'b10, 1'b1, 32'h0403_0201}) begin bad++; $display("FAIL gap_freeze_out: got %h want %h", o, {2'b10, 1'b1, 32'h0403_0201}); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b00, 1'b0, 32'h0807_0605}) begin bad++; $display("FAIL gap_hi: got %h want %h", o, {2'b00, 1'b0, 32'h0807_0605}); end
  endtask

  task automatic test_reset_mid_block();
    logic [34:0] o, e;
    step(32'h5555_55FB, 4'h1, 1'b1, o, e);
    test_reset();
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== {2'b01, 1'b1, 32'h0000_001E}) begin bad++; $display("FAIL midreset_lo: got %h want %h", o, {2'b01, 1'b1, 32'h0000_001E}); end
    step(IDLE_D, IDLE_C, 1'b1, o, e);
    total++;
    if (o !== 35'h0) begin bad++; $display("FAIL midreset_hi: got %h want 0", o); end
  endtask

  task automatic gen_block(output logic [7:0] c, output logic [63:0] d);
    int k;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: c = 8'h00;
      1: begin
        c = 8'hFF;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = ($urandom_range(0, 4) == 0) ? 8'hFE : 8'h07;
      end
      2: begin c = 8'h01; d[7:0] = 8'hFB; end
      3: begin c = 8'h1F; d[39:0] = 40'hFB_0707_0707; end
      4: begin
        k = $urandom_range(0, 7);
        c = 8'hFF << k;
        d[8*k +: 8] = 8'hFD;
        for (int i = k + 1; i < 8; i++) d[8*i +: 8] = 8'h07;
        if ($urandom_range(0, 5) == 0) d[8*($urandom_range(0, 7)) +: 8] = 8'h9C;
      end
      default: c = 8'($urandom);
    endcase
  endtask

  task automatic test_random();
    logic [34:0] o, e;
    logic [7:0]  c;
    logic [63:0] d;
    for (int n = 0; n < 200; n++) begin
      gen_block(c, d);
      for (int h = 0; h < 2; h++) begin
        while ($urandom_range(0, 3) == 0) begin
          step(d[32*h +: 32], c[4*h +: 4], 1'b0, o, e);
          total++;
          if (o !== e) begin bad++; $display("FAIL random_stall[%0d]: got %h want %h", n, o, e); end
        end
        step(d[32*h +: 32], c[4*h +: 4], 1'b1, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL random[%0d.%0d]: got %h want %h", n, h, o, e); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; i_ready = 1'b0; xgmii_txd = IDLE_D; xgmii_txc = IDLE_C;
    model_reset();
    test_reset();
    test_idle();
    test_start();
    test_data();
    test_terminate();
    test_error();
    test_ready_gap();
    test_reset_mid_block();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
